cla_chunk_seq_adder: RTL and testbench
======================================

Name: cla_chunk_seq_adder

Overview:
- Multi-cycle wide adder controller. Adds two WIDTH-bit operands plus carry-in by stepping one CHUNK-bit carry-lookahead slice across the operand, least significant chunk first.
- The carry ripples between chunks through a registered carry.
- Used where a full-width CLA tree is too large. Valid/ready handshake on both sides; one operation in flight.

Parameters:
- WIDTH, 32, operand/sum width; must be an integer multiple of CHUNK, otherwise elaboration error.
- CHUNK, 4, bits added per cycle by the internal CLA slice; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  registered result
- cout  out  1  registered carry-out
- busy  out  1  state != IDLE

Behaviour:
- Bit terms: p_i = a_i ^ b_i, g_i = a_i & b_i.
- Chunk k uses group Px = AND of chunk p. Group Gx = OR over j of (g_j AND p of all higher bits in the chunk).
- Chunk sum bits: p_i ^ c_i, where c_i is the lookahead carry from the registered carry.
- Carry update: carry <= Gx | (Px & carry).
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, capture a, b, cin into internal regs; carry<=cin; idx<=0; -> RUN.
  - RUN: each cycle process chunk idx: write sum[idx*CHUNK +: CHUNK], update carry, idx<=idx+1. On the cycle idx==NCHUNK-1: cout<=final carry, -> DONE.
  - DONE: out_valid=1; sum and cout held stable. On out_valid & out_ready -> IDLE.
- Latency: out_valid rises exactly NCHUNK clock edges after the accepting edge. NCHUNK=1 gives 1 cycle of RUN.
- in_ready=0 in RUN and DONE. in_valid is ignored there; no overlap or queueing.
- in_ready is combinational from state only (no path from in_valid or out_ready).
- sum is partial and undefined-to-consumer while not out_valid.
- out_ready high outside DONE has no effect.
- Reset (async, any state including mid-RUN): state=IDLE, idx=0, carry=0, sum=0, cout=0, out_valid=0, busy=0, in_ready=1 (in_valid is ignored while rst_n low). Captured operands are discarded.
- Arithmetic is modulo 2^WIDTH; the overflow carry appears only on cout.

Optional Feature:
- Macro CLA_SEQ_GROUP_PG_EN.
- Defined: adds outputs grp_p (1) and grp_g (1), updated alongside the chunk steps and valid with out_valid.
  - grp_p: starts at 1; grp_p <= grp_p & Px.
  - grp_g: starts at 0; grp_g <= Gx | (Px & grp_g).
  - Result: whole-operand propagate/generate for use by a higher-level lookahead stage. Both reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- WIDTH=32, CHUNK=4; a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, out_valid exactly 8 edges after accept.
- a=0x12345678, b=0x9ABCDEF0, cin=1 -> sum=0xACF13569, cout=0; busy high for the 8 RUN cycles plus DONE.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/cout/out_valid stable, in_ready=0, a new in_valid is not accepted. Raise out_ready -> IDLE next edge, in_ready=1, next op accepted.
- Reset mid-RUN (after 3 chunks): assert rst_n low -> out_valid=0, busy=0, sum=0, cout=0 immediately. After release, a=0x00000003, b=0x00000005, cin=0 -> sum=0x00000008, cout=0.
- CLA_SEQ_GROUP_PG_EN defined:
  - a=0xFFFFFFFF, b=0x00000000, cin=1 -> grp_p=1, grp_g=0, sum=0, cout=1.
  - a=0x80000000, b=0x80000000 -> grp_p=0, grp_g=1, cout=1.
- CHUNK=WIDTH=8 (NCHUNK=1): 200 random operands compared against a+b+cin with back-to-back requests -> every result matches, out_valid 1 edge after each accept.

Source files
------------

// File: rtl/cla_chunk_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit carry-lookahead slice stepped LSB-first, carry registered between chunks.
// Optional macro CLA_SEQ_GROUP_PG_EN adds whole-operand group propagate/generate outputs grp_p/grp_g.
module cla_chunk_seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_SEQ_GROUP_PG_EN
  ,
  output logic             grp_p,
  output logic             grp_g
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_width
      $error("cla_chunk_seq_adder: WIDTH must be an integer multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [CHUNK-1:0] aChunk, bChunk, pBits, gBits, chunkSum;
  logic [CHUNK-1:0] c;
  logic             grpPx, grpGx, carryNext;
  int               off;

  // Lookahead slice over the chunk selected by idx, seeded from the registered carry.
  always_comb begin
    off    = int'(idx_q) * CHUNK;
    aChunk = a_q[off +: CHUNK];
    bChunk = b_q[off +: CHUNK];
    pBits  = aChunk ^ bChunk;
    gBits  = aChunk & bChunk;
    grpPx  = &pBits;
    grpGx  = 1'b0;
    c      = '0;
    c[0]   = carry_q;
    for (int j = 1; j < CHUNK; j++) begin
      c[j] = gBits[j-1] | (pBits[j-1] & c[j-1]);
    end
    for (int j = 0; j < CHUNK; j++) begin
      grpGx = gBits[j] | (pBits[j] & grpGx);
    end
    chunkSum  = pBits ^ c;
    carryNext = grpGx | (grpPx & carry_q);
  end

`ifdef CLA_SEQ_GROUP_PG_EN
  logic grpP_q, grpP_d, grpG_q, grpG_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CLA_SEQ_GROUP_PG_EN
    grpP_d  = grpP_q;
    grpG_d  = grpG_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
`ifdef CLA_SEQ_GROUP_PG_EN
          grpP_d  = 1'b1;
          grpG_d  = 1'b0;
`endif
        end
      end
      RUN: begin
        sum_d[off +: CHUNK] = chunkSum;
        carry_d = carryNext;
        idx_d   = idx_q + IDXW'(1);
`ifdef CLA_SEQ_GROUP_PG_EN
        grpP_d  = grpP_q & grpPx;
        grpG_d  = grpGx | (grpPx & grpG_q);
`endif
        if (idx_q == IDXW'(NCHUNK - 1)) begin
          idx_d   = '0;
          cout_d  = carryNext;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CLA_SEQ_GROUP_PG_EN
      grpP_q  <= 1'b0;
      grpG_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CLA_SEQ_GROUP_PG_EN
      grpP_q  <= grpP_d;
      grpG_q  <= grpG_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CLA_SEQ_GROUP_PG_EN
  assign grp_p     = grpP_q;
  assign grp_g     = grpG_q;
`endif

endmodule

// File: tb/tb_cla_chunk_seq_adder.sv
// Self-checking bench: a 32/4 instance for directed and random checks, and an 8/8 instance for single-chunk back-to-back traffic.
module tb_cla_chunk_seq_adder;

  logic clk = 1'b0;
  logic rst_n;

  logic        inValid32, inReady32, cin32, outValid32, outReady32, cout32, busy32;
  logic [31:0] a32, b32, sum32;
  logic        inValid8, inReady8, cin8, outValid8, outReady8, cout8, busy8;
  logic [7:0]  a8, b8, sum8;
`ifdef CLA_SEQ_GROUP_PG_EN
  logic grpP32, grpG32, grpP8, grpG8;
`endif

  int nAssert = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  cla_chunk_seq_adder #(.WIDTH(32), .CHUNK(4)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid32), .in_ready(inReady32),
    .a(a32), .b(b32), .cin(cin32),
    .out_valid(outValid32), .out_ready(outReady32),
    .sum(sum32), .cout(cout32), .busy(busy32)
`ifdef CLA_SEQ_GROUP_PG_EN
    , .grp_p(grpP32), .grp_g(grpG32)
`endif
  );

  cla_chunk_seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid8), .in_ready(inReady8),
    .a(a8), .b(b8), .cin(cin8),
    .out_valid(outValid8), .out_ready(outReady8),
    .sum(sum8), .cout(cout8), .busy(busy8)
`ifdef CLA_SEQ_GROUP_PG_EN
    , .grp_p(grpP8), .grp_g(grpG8)
`endif
  );

  // Drives one request into the 32-bit DUT and counts edges from accept to out_valid (bounded at 20).
  task automatic applyStimulus(input logic [31:0] aa, input logic [31:0] bb, input logic cc,
                               output int edges, output logic busyOk);
    @(negedge clk);
    a32 = aa; b32 = bb; cin32 = cc; inValid32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid32 = 1'b0;
    edges  = 0;
    busyOk = busy32;
    while (!outValid32 && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      busyOk &= busy32;
    end
  endtask

  task automatic releaseResult();
    @(negedge clk);
    outReady32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady32 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    nAssert++;
    if ({outValid32, busy32, inReady32, cout32, sum32} !== {1'b0, 1'b0, 1'b1, 1'b0, 32'h0}) begin
      nFail++;
      $display("[TB] FAIL reset32 got ov=%b busy=%b ir=%b cout=%b sum=%h, want 0 0 1 0 0",
               outValid32, busy32, inReady32, cout32, sum32);
    end
    nAssert++;
    if ({outValid8, busy8, inReady8, cout8, sum8} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h0}) begin
      nFail++;
      $display("[TB] FAIL reset8 got ov=%b busy=%b ir=%b cout=%b sum=%h, want 0 0 1 0 0",
               outValid8, busy8, inReady8, cout8, sum8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_carry_chain();
    int edges; logic busyOk;
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, edges, busyOk);
    nAssert++;
    if (edges !== 8) begin
      nFail++; $display("[TB] FAIL chain_latency got %0d edges, want 8", edges);
    end
    nAssert++;
    if ({cout32, sum32} !== {1'b1, 32'h0}) begin
      nFail++; $display("[TB] FAIL chain_result got cout=%b sum=%h, want 1 00000000", cout32, sum32);
    end
    releaseResult();
  endtask

  task automatic test_mixed();
    int edges; logic busyOk;
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, edges, busyOk);
    nAssert++;
    if ({cout32, sum32} !== {1'b0, 32'hACF1_3569}) begin
      nFail++; $display("[TB] FAIL mixed_result got cout=%b sum=%h, want 0 acf13569", cout32, sum32);
    end
    nAssert++;
    if (busyOk !== 1'b1 || edges !== 8) begin
      nFail++; $display("[TB] FAIL mixed_busy got busyOk=%b edges=%0d, want 1 8", busyOk, edges);
    end
    releaseResult();
    nAssert++;
    if ({busy32, inReady32} !== 2'b01) begin
      nFail++; $display("[TB] FAIL mixed_idle got busy=%b ir=%b, want 0 1", busy32, inReady32);
    end
  endtask

  task automatic test_backpressure();
    int edges; logic busyOk;
    logic [31:0] aa, bb; logic cc; logic [32:0] expect33; logic [32:0] held;
    aa = $urandom; bb = $urandom; cc = 1'($urandom);
    expect33 = {1'b0, aa} + {1'b0, bb} + 33'(cc);
    applyStimulus(aa, bb, cc, edges, busyOk);
    held = {cout32, sum32};
    nAssert++;
    if (held !== expect33) begin
      nFail++; $display("[TB] FAIL bp_result got %h, want %h", held, expect33);
    end
    for (int i = 0; i < 5; i++) begin
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); inValid32 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      nAssert++;
      if ({outValid32, inReady32, cout32, sum32} !== {1'b1, 1'b0, expect33}) begin
        nFail++;
        $display("[TB] FAIL bp_hold cycle %0d got ov=%b ir=%b res=%h, want 1 0 %h",
                 i, outValid32, inReady32, {cout32, sum32}, expect33);
      end
    end
    inValid32 = 1'b0;
    outReady32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady32 = 1'b0;
    nAssert++;
    if ({outValid32, inReady32} !== 2'b01) begin
      nFail++; $display("[TB] FAIL bp_release got ov=%b ir=%b, want 0 1", outValid32, inReady32);
    end
    aa = $urandom; bb = $urandom; cc = 1'($urandom);
    expect33 = {1'b0, aa} + {1'b0, bb} + 33'(cc);
    applyStimulus(aa, bb, cc, edges, busyOk);
    nAssert++;
    if ({cout32, sum32} !== expect33 || edges !== 8) begin
      nFail++; $display("[TB] FAIL bp_next got %h edges=%0d, want %h edges=8", {cout32, sum32}, edges, expect33);
    end
    releaseResult();
  endtask

  task automatic test_reset_mid_run();
    int edges; logic busyOk;
    @(negedge clk);
    a32 = 32'hDEAD_BEEF; b32 = 32'h1357_9BDF; cin32 = 1'b1; inValid32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid32 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nAssert++;
    if ({outValid32, busy32, inReady32, cout32, sum32} !== {1'b0, 1'b0, 1'b1, 1'b0, 32'h0}) begin
      nFail++;
      $display("[TB] FAIL midrun_reset got ov=%b busy=%b ir=%b cout=%b sum=%h, want 0 0 1 0 0",
               outValid32, busy32, inReady32, cout32, sum32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'h0000_0003, 32'h0000_0005, 1'b0, edges, busyOk);
    nAssert++;
    if ({cout32, sum32} !== {1'b0, 32'h0000_0008} || edges !== 8) begin
      nFail++; $display("[TB] FAIL midrun_after got cout=%b sum=%h edges=%0d, want 0 00000008 8", cout32, sum32, edges);
    end
    releaseResult();
  endtask

  // Random 32-bit traffic; group P/G expectations come from whole-word arithmetic.
  task automatic test_random32();
    int edges; logic busyOk;
    logic [31:0] aa, bb; logic cc; logic [32:0] expect33;
    for (int i = 0; i < 20; i++) begin
      aa = $urandom; bb = $urandom; cc = 1'($urandom);
      if (i == 0) begin aa = 32'hFFFF_FFFF; bb = 32'h0; cc = 1'b1; end
      expect33 = {1'b0, aa} + {1'b0, bb} + 33'(cc);
      applyStimulus(aa, bb, cc, edges, busyOk);
      nAssert++;
      if ({cout32, sum32} !== expect33 || edges !== 8) begin
        nFail++; $display("[TB] FAIL rand32 #%0d got %h edges=%0d, want %h edges=8", i, {cout32, sum32}, edges, expect33);
      end
`ifdef CLA_SEQ_GROUP_PG_EN
      begin
        logic [32:0] noCin;
        noCin = {1'b0, aa} + {1'b0, bb};
        nAssert++;
        if ({grpP32, grpG32} !== {(aa ^ bb) == 32'hFFFF_FFFF, noCin[32]}) begin
          nFail++; $display("[TB] FAIL rand32_pg #%0d got p=%b g=%b", i, grpP32, grpG32);
        end
      end
`endif
      releaseResult();
    end
  endtask

`ifdef CLA_SEQ_GROUP_PG_EN
  task automatic test_group_pg();
    int edges; logic busyOk;
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, edges, busyOk);
    nAssert++;
    if ({grpP32, grpG32, cout32, sum32} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
      nFail++; $display("[TB] FAIL pg_prop got p=%b g=%b cout=%b sum=%h, want 1 0 1 0", grpP32, grpG32, cout32, sum32);
    end
    releaseResult();
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, edges, busyOk);
    nAssert++;
    if ({grpP32, grpG32, cout32, sum32} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      nFail++; $display("[TB] FAIL pg_gen got p=%b g=%b cout=%b sum=%h, want 0 1 1 0", grpP32, grpG32, cout32, sum32);
    end
    releaseResult();
  endtask
`endif

  // Single-chunk instance with out_ready held high: accept, 1 RUN edge, DONE, back to IDLE.
  task automatic test_back_to_back();
    logic [8:0] expect9, nextExpect9;
    logic [7:0] aa, bb; logic cc;
    outReady8 = 1'b1;
    @(negedge clk);
    aa = 8'($urandom); bb = 8'($urandom); cc = 1'($urandom);
    a8 = aa; b8 = bb; cin8 = cc; inValid8 = 1'b1;
    nextExpect9 = {1'b0, aa} + {1'b0, bb} + 9'(cc);
    for (int i = 0; i < 200; i++) begin
      expect9 = nextExpect9;
      @(posedge clk);
      @(negedge clk);
      nAssert++;
      if (outValid8 !== 1'b0) begin
        nFail++; $display("[TB] FAIL b2b_early #%0d got ov=%b, want 0", i, outValid8);
      end
      aa = 8'($urandom); bb = 8'($urandom); cc = 1'($urandom);
      a8 = aa; b8 = bb; cin8 = cc;
      nextExpect9 = {1'b0, aa} + {1'b0, bb} + 9'(cc);
      if (i == 199) inValid8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      nAssert++;
      if ({outValid8, cout8, sum8} !== {1'b1, expect9}) begin
        nFail++; $display("[TB] FAIL b2b_result #%0d got ov=%b res=%h, want 1 %h", i, outValid8, {cout8, sum8}, expect9);
      end
      @(posedge clk);
      @(negedge clk);
      nAssert++;
      if (inReady8 !== 1'b1) begin
        nFail++; $display("[TB] FAIL b2b_ready #%0d got ir=%b, want 1", i, inReady8);
      end
    end
    outReady8 = 1'b0;
  endtask

  initial begin
    inValid32 = 1'b0; outReady32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
    inValid8 = 1'b0; outReady8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    test_reset();
    test_carry_chain();
    test_mixed();
    test_backpressure();
    test_reset_mid_run();
    test_random32();
`ifdef CLA_SEQ_GROUP_PG_EN
    test_group_pg();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
